di_packet_scheduler: RTL and testbench
======================================

Name: di_packet_scheduler

Overview:
- Schedules HDMI data islands in horizontal blanking on every line.
- Arbitrates up to NUM_PKT_REQ packet sources (ACR, audio sample, AVI infoframe, audio infoframe) for the shared 32-cycle packet slot.
- Drives the per-cycle period mode, one-hot grant, and packet bit counter to the TMDS channel encoders and the packet assembler.
- Sits inside hdmi_top between the video timing counters and the TERC4/packet datapath, in the I_clk_pixel domain.

Parameters:
- DI_OFFSET, 10: pixels after screenWidth at which an island may open.
- VIDEO_RESERVE, 14: pixels before frameWidth kept free for the control period, video preamble and video guard.
- MAX_PACKETS, 18: packets per island limit, set by HDMI.

Ports:
- I_clk_pixel  in  1  pixel clock.
- I_reset  in  1  synchronous reset, active-high.
- pixX  in  VIDEO_X_BITWIDTH  current pixel column (active region is pixX < screenWidth).
- screenWidth  in  VIDEO_X_BITWIDTH  active width.
- frameWidth  in  VIDEO_X_BITWIDTH  total line length.
- I_req  in  NUM_PKT_REQ  level request per source; held until acked. Bit 0 has highest priority.
- O_mode  out  di_mode_t  CTRL / PREAMBLE / GUARD / DATA.
- O_grant  out  NUM_PKT_REQ  one-hot owner of the current DATA slot; 0 otherwise.
- O_pkt_cnt  out  5  bit index 0..31 within the packet.
- O_pkt_start  out  1  pulse on the first DATA cycle of each packet.
- O_ack  out  NUM_PKT_REQ  one-cycle pulse on the granted bit, in the last DATA cycle (pkt_cnt=31).
- O_overrun  out  1  sticky; set if an island is cut by a line wrap.

Behaviour:
- Clock and reset: one clock, I_clk_pixel. I_reset is synchronous and active-high.
- Output timing: all outputs are registered. The output in cycle n reflects the decision made from pixX in cycle n-1. Output position is defined as p = decision pixX + 1.
- Reset values: O_mode=CTRL, O_grant=0, O_pkt_cnt=0, O_pkt_start=0, O_ack=0, O_overrun=0, state IDLE.
- Reset mid-island: next cycle returns to IDLE/CTRL with no ack issued. The requester keeps its request, and the packet is re-sent later.
- State IDLE: if pixX == screenWidth+DI_OFFSET and |I_req and the first packet fits, go to PREAMBLE. Otherwise stay IDLE.
- State PREAMBLE: 8 cycles of O_mode=PREAMBLE, then LEAD_GUARD.
- State LEAD_GUARD: 2 cycles of GUARD, then PACKET.
- State PACKET: 32 cycles of DATA; O_pkt_cnt counts 0..31. The grant is latched at packet start and is stable for all 32 cycles.
- Next-packet decision, made in the cycle showing pkt_cnt=31, using I_req masked by the bit being acked:
  - Another packet is sent if a request is pending, packets sent < MAX_PACKETS, and the fit rule holds. The next packet starts back-to-back with no guard.
  - Otherwise go to TRAIL_GUARD.
- State TRAIL_GUARD: 2 cycles of GUARD, then IDLE. Only one island is opened per line.
- Fit rule: a packet whose first DATA output position is s is allowed only if s + 32 + 2 <= frameWidth - VIDEO_RESERVE. This is checked before the first packet too; if the first packet fails, no island opens.
- Arbitration: fixed priority, lowest index wins, sampled at the decision cycle.
- Request rules: requests that rise mid-packet wait for the next boundary. An acked source must drop I_req, or it re-wins the next slot.
- Simultaneous requests: all bits set are served in index order across slots and lines.
- Line wrap: if pixX == 0 while not IDLE, force IDLE/CTRL, set O_overrun, and issue no ack. This only happens if frameWidth changes mid-line.
- Arithmetic: position comparisons are done at VIDEO_X_BITWIDTH+1 bits to avoid overflow.

Decomposition:
- configPackage additions:
  - typedef enum di_mode_t {CTRL, PREAMBLE, GUARD, DATA}.
  - Constants DI_PREAMBLE_LEN=8, DI_GUARD_LEN=2, DI_PACKET_LEN=32, DI_MAX_PACKETS=18, NUM_PKT_REQ=4.
- Sub-module packet_arbiter: combinational fixed-priority one-hot select plus an any-pending flag.

Test Plan:
- 480p (screenWidth 720, frameWidth 858), I_req=0001 held until ack -> PREAMBLE at p=731..738, GUARD 739..740, DATA 741..772 with grant 0001, ack at p=772, GUARD 773..774, then CTRL.
- 480p, I_req=1111, each bit dropped on its ack -> packets at s=741, 773, 805 granted 0001, 0010, 0100. s=837 fails the fit rule (871 > 844), so TRAIL_GUARD at 837..838. Bit 3 is served first on the next line at s=741.
- 720p (1280/1650), all sources re-requesting continuously -> exactly 10 packets (s=1301..1589) per line, and the island never extends past p=1623.
- I_req=0 at the trigger -> O_mode stays CTRL for the whole line. Bit 2 raised at pkt_cnt=10 of a bit-0 packet -> bit 2 wins the next slot.
- I_reset asserted at pkt_cnt=15 -> next cycle CTRL with grant 0 and no ack. After release, the same request is served on the next line.
- frameWidth reduced to 760 while in PACKET at 480p -> pixX wraps to 0, the block goes IDLE, and O_overrun=1 stays set until reset.

Source files
------------

// File: rtl/di_packet_scheduler_pkg.sv
`default_nettype none
//==============================================================================
// di_packet_scheduler_pkg : shared types and constants for data-island scheduling
// Revision: 1.0
//==============================================================================
package di_packet_scheduler_pkg;

    typedef enum logic [1:0] {
        CTRL     = 2'd0,
        PREAMBLE = 2'd1,
        GUARD    = 2'd2,
        DATA     = 2'd3
    } di_mode_t;

    localparam int DI_PREAMBLE_LEN = 8;
    localparam int DI_GUARD_LEN    = 2;
    localparam int DI_PACKET_LEN   = 32;
    localparam int DI_MAX_PACKETS  = 18;
    localparam int NUM_PKT_REQ     = 4;

endpackage
`default_nettype wire

// File: rtl/di_packet_scheduler_if.sv
`default_nettype none
//==============================================================================
// di_packet_scheduler_if : request/grant and period-mode bus of the scheduler
// Revision: 1.0
//==============================================================================
interface di_packet_scheduler_if
    import di_packet_scheduler_pkg::*;
();

    logic [NUM_PKT_REQ-1:0] I_req;
    di_mode_t               O_mode;
    logic [NUM_PKT_REQ-1:0] O_grant;
    logic [4:0]             O_pkt_cnt;
    logic                   O_pkt_start;
    logic [NUM_PKT_REQ-1:0] O_ack;
    logic                   O_overrun;

    modport master (
        input  I_req,
        output O_mode, O_grant, O_pkt_cnt, O_pkt_start, O_ack, O_overrun
    );

    modport slave (
        output I_req,
        input  O_mode, O_grant, O_pkt_cnt, O_pkt_start, O_ack, O_overrun
    );

endinterface
`default_nettype wire

// File: rtl/di_packet_scheduler_packet_arbiter.sv
`default_nettype none
//==============================================================================
// packet_arbiter : fixed-priority one-hot select, lowest index wins
// Revision: 1.0
//==============================================================================
module packet_arbiter #(
    parameter int N = 4
) (
    input  wire [N-1:0] req_i,
    output logic [N-1:0] grant_o,
    output logic         any_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant_o = req_i & (~req_i + N'(1));
    assign any_o   = |req_i;

endmodule
`default_nettype wire

// File: rtl/di_packet_scheduler.sv
`default_nettype none
//==============================================================================
// di_packet_scheduler : places one data island per line in horizontal blanking
// Revision: 1.0
//==============================================================================
module di_packet_scheduler
    import di_packet_scheduler_pkg::*;
#(
    parameter int VIDEO_X_BITWIDTH = 12,
    parameter int DI_OFFSET        = 10,
    parameter int VIDEO_RESERVE    = 14,
    parameter int MAX_PACKETS      = DI_MAX_PACKETS
) (
    input  wire                        I_clk_pixel,
    input  wire                        I_reset,
    input  wire [VIDEO_X_BITWIDTH-1:0] pixX,
    input  wire [VIDEO_X_BITWIDTH-1:0] screenWidth,
    input  wire [VIDEO_X_BITWIDTH-1:0] frameWidth,
    di_packet_scheduler_if.master      bus
);

    localparam int XW = VIDEO_X_BITWIDTH + 1;
    localparam int FIRST_SPAN = 1 + DI_PREAMBLE_LEN + 2 * DI_GUARD_LEN + DI_PACKET_LEN + VIDEO_RESERVE;
    localparam int NEXT_SPAN  = 1 + DI_PACKET_LEN + DI_GUARD_LEN + VIDEO_RESERVE;

    localparam logic [2:0] c_ST_IDLE        = 3'd0;
    localparam logic [2:0] c_ST_PREAMBLE    = 3'd1;
    localparam logic [2:0] c_ST_LEAD_GUARD  = 3'd2;
    localparam logic [2:0] c_ST_PACKET      = 3'd3;
    localparam logic [2:0] c_ST_TRAIL_GUARD = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [4:0]             sent_q, sent_d;
    logic [NUM_PKT_REQ-1:0] grant_q, grant_d;

    di_mode_t               mode_q, mode_d;
    logic [NUM_PKT_REQ-1:0] grant_out_q, grant_out_d;
    logic [4:0]             pkt_cnt_q, pkt_cnt_d;
    logic                   start_q, start_d;
    logic [NUM_PKT_REQ-1:0] ack_q, ack_d;
    logic                   overrun_q, overrun_d;

    logic                   wrap_w;
    logic [XW-1:0]          pix_w;
    logic                   trigger_w, first_fits_w, next_fits_w;
    logic [NUM_PKT_REQ-1:0] arb_req_w, arb_grant_w;
    logic                   arb_any_w;

    // Positions are widened by one bit so the fit sums cannot wrap.
    assign pix_w        = {1'b0, pixX};
    assign trigger_w    = (pix_w == ({1'b0, screenWidth} + XW'(DI_OFFSET)));
    assign first_fits_w = ((pix_w + XW'(FIRST_SPAN)) <= {1'b0, frameWidth});
    assign next_fits_w  = ((pix_w + XW'(NEXT_SPAN)) <= {1'b0, frameWidth});

    assign arb_req_w = (state_q == c_ST_PACKET) ? (bus.I_req & ~grant_q) : bus.I_req;

    packet_arbiter #(.N(NUM_PKT_REQ)) u_arbiter (
        .req_i   (arb_req_w),
        .grant_o (arb_grant_w),
        .any_o   (arb_any_w)
    );

    always_ff @(posedge I_clk_pixel) begin
        if (I_reset) begin
            state_q     <= c_ST_IDLE;
            cnt_q       <= '0;
            sent_q      <= '0;
            grant_q     <= '0;
            mode_q      <= CTRL;
            grant_out_q <= '0;
            pkt_cnt_q   <= '0;
            start_q     <= 1'b0;
            ack_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sent_q      <= sent_d;
            grant_q     <= grant_d;
            mode_q      <= mode_d;
            grant_out_q <= grant_out_d;
            pkt_cnt_q   <= pkt_cnt_d;
            start_q     <= start_d;
            ack_q       <= ack_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sent_d  = sent_q;
        grant_d = grant_q;
        wrap_w  = 1'b0;
        if (state_q != c_ST_IDLE && pixX == '0) begin
            state_d = c_ST_IDLE;
            cnt_d   = '0;
            sent_d  = '0;
            grant_d = '0;
            wrap_w  = 1'b1;
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    if (trigger_w && (|bus.I_req) && first_fits_w) begin
                        state_d = c_ST_PREAMBLE;
                        cnt_d   = '0;
                        sent_d  = '0;
                        grant_d = '0;
                    end
                end
                c_ST_PREAMBLE: begin
                    if (cnt_q == 5'(DI_PREAMBLE_LEN - 1)) begin
                        state_d = c_ST_LEAD_GUARD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                c_ST_LEAD_GUARD: begin
                    if (cnt_q == 5'(DI_GUARD_LEN - 1)) begin
                        cnt_d = '0;
                        if (arb_any_w) begin
                            state_d = c_ST_PACKET;
                            grant_d = arb_grant_w;
                            sent_d  = sent_q + 5'd1;
                        end else begin
                            state_d = c_ST_TRAIL_GUARD;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                c_ST_PACKET: begin
                    if (cnt_q == 5'(DI_PACKET_LEN - 1)) begin
                        cnt_d = '0;
                        if (arb_any_w && (sent_q < 5'(MAX_PACKETS)) && next_fits_w) begin
                            grant_d = arb_grant_w;
                            sent_d  = sent_q + 5'd1;
                        end else begin
                            state_d = c_ST_TRAIL_GUARD;
                            grant_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                c_ST_TRAIL_GUARD: begin
                    if (cnt_q == 5'(DI_GUARD_LEN - 1)) begin
                        state_d = c_ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = c_ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        mode_d      = CTRL;
        grant_out_d = '0;
        pkt_cnt_d   = '0;
        start_d     = 1'b0;
        ack_d       = '0;
        overrun_d   = overrun_q | wrap_w;
        case (state_d)
            c_ST_PREAMBLE:                      mode_d = PREAMBLE;
            c_ST_LEAD_GUARD, c_ST_TRAIL_GUARD:  mode_d = GUARD;
            c_ST_PACKET: begin
                mode_d      = DATA;
                grant_out_d = grant_d;
                pkt_cnt_d   = cnt_d;
                start_d     = (cnt_d == '0);
                if (cnt_d == 5'(DI_PACKET_LEN - 1)) begin
                    ack_d = grant_d;
                end
            end
            default: ;
        endcase
    end

    assign bus.O_mode      = mode_q;
    assign bus.O_grant     = grant_out_q;
    assign bus.O_pkt_cnt   = pkt_cnt_q;
    assign bus.O_pkt_start = start_q;
    assign bus.O_ack       = ack_q;
    assign bus.O_overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_di_packet_scheduler.sv
`default_nettype none
//==============================================================================
// tb_di_packet_scheduler : scoreboard bench with a line-level reference model
// Revision: 1.0
//==============================================================================
module tb_di_packet_scheduler;
    import di_packet_scheduler_pkg::*;

    typedef struct {
        int         due;
        int         p;
        di_mode_t   mode;
        logic [3:0] grant;
        logic [4:0] cnt;
        logic       start;
        logic [3:0] ack;
        logic       ovr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] pix_x = '0;
    logic [11:0] scr_w = 12'd720;
    logic [11:0] frm_w = 12'd858;

    di_packet_scheduler_if bus ();

    di_packet_scheduler #(.VIDEO_X_BITWIDTH(12)) dut (
        .I_clk_pixel (clk),
        .I_reset     (rst),
        .pixX        (pix_x),
        .screenWidth (scr_w),
        .frameWidth  (frm_w),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    // Stimulus-side state.
    int         x = 0;
    int         sw_v = 720;
    int         fw_v = 858;
    logic [3:0] req_m = '0;
    bit         rst_req = 1'b0;
    bit         rereq_all = 1'b0;
    int         rand_rate = 0;
    bit         hook_raise2 = 1'b0;
    bit         hook_rst15 = 1'b0;
    int         hook_fw_x = -1;

    // Reference model state: island in progress, its start and packet grants.
    bit         m_active = 1'b0;
    int         m_p0 = 0;
    int         m_trail = -1;
    logic [3:0] m_grants[$];
    bit         m_ovr = 1'b0;

    // Observations from the DUT for line-level checks.
    int         start_cnt = 0;
    int         last_busy_p = 0;

    function automatic logic [3:0] lowbit(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 4'b0001 << i;
        return 4'b0000;
    endfunction

    function automatic exp_t model(input int px, input logic [3:0] rq, input bit r);
        exp_t e;
        int   p, off, k, b;
        logic [3:0] prev, masked;
        p = px + 1;
        e.due = cyc + 1; e.p = p; e.mode = CTRL; e.grant = '0;
        e.cnt = '0; e.start = 1'b0; e.ack = '0;
        if (r) begin
            m_active = 1'b0; m_ovr = 1'b0; m_grants.delete();
        end else if (m_active && px == 0) begin
            m_active = 1'b0; m_ovr = 1'b1;
        end else if (!m_active) begin
            if (px == sw_v + 10 && rq != 0 && p + 10 + 34 <= fw_v - 14) begin
                m_active = 1'b1; m_p0 = p; m_trail = -1; m_grants.delete();
                e.mode = PREAMBLE;
            end
        end else begin
            off = p - m_p0;
            if (off < 8) e.mode = PREAMBLE;
            else if (off < 10) e.mode = GUARD;
            else if (m_trail >= 0) begin
                if (p < m_trail + 2) e.mode = GUARD;
                else m_active = 1'b0;
            end else begin
                k = (off - 10) / 32;
                b = (off - 10) % 32;
                if (b == 0) begin
                    prev   = (k > 0) ? m_grants[k-1] : 4'b0000;
                    masked = rq & ~prev;
                    if (masked != 0 && k < 18 && (k == 0 || p + 34 <= fw_v - 14))
                        m_grants.push_back(lowbit(masked));
                    else
                        m_trail = p;
                end
                if (m_trail >= 0) e.mode = GUARD;
                else begin
                    e.mode  = DATA;
                    e.grant = m_grants[k];
                    e.cnt   = 5'(b);
                    e.start = (b == 0);
                    e.ack   = (b == 31) ? m_grants[k] : 4'b0000;
                end
            end
        end
        e.ovr = m_ovr;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (!req_m[i]) begin
                if (rereq_all) req_m[i] = 1'b1;
                else if (rand_rate != 0 && $urandom_range(rand_rate - 1) == 0) req_m[i] = 1'b1;
            end
        end
        rst       = rst_req;
        bus.I_req = req_m;
        pix_x     = 12'(x);
        scr_w     = 12'(sw_v);
        frm_w     = 12'(fw_v);
        e = model(x, req_m, rst_req);
        sb.push_back(e);
        req_m = req_m & ~e.ack;
        if (hook_raise2 && e.mode == DATA && e.cnt == 5'd10 && e.grant == 4'b0001) begin
            req_m[2] = 1'b1; hook_raise2 = 1'b0;
        end
        if (hook_rst15 && e.mode == DATA && e.cnt == 5'd15) begin
            rst_req = 1'b1; hook_rst15 = 1'b0;
        end else begin
            rst_req = 1'b0;
        end
        if (hook_fw_x >= 0 && x == hook_fw_x) begin
            fw_v = 760; hook_fw_x = -1;
        end
        x = (x + 1 >= fw_v) ? 0 : x + 1;
    endtask

    task automatic run_line(input int w, input int f);
        sw_v = w; fw_v = f;
        do step(); while (x != 0);
    endtask

    // Monitor: compares every registered output cycle against the scoreboard.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.O_mode !== e.mode || bus.O_grant !== e.grant || bus.O_pkt_cnt !== e.cnt ||
                bus.O_pkt_start !== e.start || bus.O_ack !== e.ack || bus.O_overrun !== e.ovr) begin
                failures++;
                $display("FAIL outputs p=%0d got mode=%0d grant=%b cnt=%0d start=%b ack=%b ovr=%b exp mode=%0d grant=%b cnt=%0d start=%b ack=%b ovr=%b",
                         e.p, bus.O_mode, bus.O_grant, bus.O_pkt_cnt, bus.O_pkt_start, bus.O_ack, bus.O_overrun,
                         e.mode, e.grant, e.cnt, e.start, e.ack, e.ovr);
            end
            if (bus.O_pkt_start === 1'b1) start_cnt++;
            if (bus.O_mode !== CTRL) last_busy_p = e.p;
        end
    end

    task automatic check_line_packets(input string name, input int want, input int max_p);
        checks++;
        if (start_cnt != want) begin
            failures++;
            $display("FAIL %s packets got=%0d exp=%0d", name, start_cnt, want);
        end
        checks++;
        if (last_busy_p > max_p) begin
            failures++;
            $display("FAIL %s island_end got=%0d exp<=%0d", name, last_busy_p, max_p);
        end
    endtask

    initial begin
        bus.I_req = '0;
        rst_req = 1'b1;
        repeat (3) step();
        run_line(720, 858);

        req_m = 4'b0001;              // single source, single packet
        repeat (2) run_line(720, 858);

        req_m = 4'b1111;              // three fit, bit 3 spills to the next line
        repeat (2) run_line(720, 858);

        req_m = 4'b0000;              // nothing pending at the trigger
        run_line(720, 858);

        req_m = 4'b0001; hook_raise2 = 1'b1;
        repeat (2) run_line(720, 858);

        req_m = 4'b0001; hook_fw_x = 745;   // line wrap while in PACKET
        run_line(720, 858);
        run_line(720, 858);

        req_m = 4'b0001; hook_rst15 = 1'b1; // reset mid-packet, re-served next line
        repeat (2) run_line(720, 858);

        rereq_all = 1'b1;
        for (int l = 0; l < 2; l++) begin
            start_cnt = 0; last_busy_p = 0;
            run_line(1280, 1650);
            check_line_packets("720p", 10, 1623);
        end
        start_cnt = 0; last_busy_p = 0;
        run_line(720, 1400);
        check_line_packets("max_packets", 18, 1400);

        rereq_all = 1'b0; rand_rate = 300; req_m = '0;
        for (int l = 0; l < 6; l++) begin
            if (l % 2 == 0) run_line(720, 858);
            else            run_line(1280, 1650);
        end

        repeat (2) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
